// File: rtl/lab_pkg.sv
// lab_pkg: shared screen geometry, arithmetic widths and the circle FSM
// state type used by the circle engine and its screen-clear helper.
// Optional feature macro used by the engine: CIRCLE_CLEAR_EN.
package lab_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int COORD_W  = 10;   // signed point coordinates, -255..510
   localparam int CRIT_W   = 12;   // signed midpoint decision variable

   typedef enum logic [3:0] {
      IDLE,
      CLEAR,
      INIT,
      OCT1,
      OCT2,
      OCT3,
      OCT4,
      OCT5,
      OCT6,
      OCT7,
      OCT8,
      DONE
   } circle_state_t;

endpackage

// File: rtl/screen_clear.sv
// screen_clear: x-major raster counter used to wipe the framebuffer before
// a circle is drawn. Only instantiated when CIRCLE_CLEAR_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : level enable; counters hold at (0,0) while low
//   x, y       : current pixel address
//   done       : high on the final pixel (SCREEN_W-1, SCREEN_H-1)
module screen_clear
   import lab_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic       done
);

   localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
   localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (!start) begin
         x <= '0;
         y <= '0;
      end else if (y == Y_LAST) begin
         y <= '0;
         x <= (x == X_LAST) ? '0 : x + 8'd1;
      end else begin
         y <= y + 7'd1;
      end
   end

   assign done = start && (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/circle_plotter.sv
// circle_plotter: midpoint (Bresenham) circle rasteriser behind a level
// start/done handshake. Each loop iteration spends one cycle per octant,
// clipping every candidate point to the SCREEN_W x SCREEN_H framebuffer;
// in-screen points are emitted on the plot bus one per cycle.
// Macro CIRCLE_CLEAR_EN: when defined, the whole screen is first cleared to
// colour 0 (x-major) by the screen_clear sub-module.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : level request, sampled only in IDLE
//   centre_x, centre_y    : circle centre (may be off-screen)
//   radius, colour        : circle radius and pixel colour
//   done                  : high while in DONE
//   vga_x, vga_y          : plot coordinates
//   vga_colour, vga_plot  : plot colour and write strobe
module circle_plotter
   import lab_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] centre_x,
   input  logic [6:0] centre_y,
   input  logic [7:0] radius,
   input  logic [2:0] colour,
   output logic       done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);

   localparam logic signed [COORD_W-1:0] X_MAX   = COORD_W'(SCREEN_W - 1);
   localparam logic signed [COORD_W-1:0] Y_MAX   = COORD_W'(SCREEN_H - 1);
   localparam logic signed [COORD_W-1:0] C_ONE   = COORD_W'(1);
   localparam logic signed [CRIT_W-1:0]  K_ONE   = CRIT_W'(1);

   circle_state_t state, nxt_state;

   logic [7:0] cx_r;
   logic [6:0] cy_r;
   logic [7:0] r_r;
   logic [2:0] col_r;

   logic signed [COORD_W-1:0] off_x, off_y, nxt_off_x, nxt_off_y;
   logic signed [CRIT_W-1:0]  crit, nxt_crit;

   logic signed [COORD_W-1:0] y_new, x_new;
   logic signed [CRIT_W-1:0]  y_ext, x_ext;

   logic signed [COORD_W-1:0] cx_s, cy_s, px, py;
   logic                      is_oct, on_screen;

   logic       done_r, plot_en;
   logic [7:0] plot_x;
   logic [6:0] plot_y;
   logic [2:0] plot_col;

`ifdef CIRCLE_CLEAR_EN
   logic [7:0] clr_x;
   logic [6:0] clr_y;
   logic       clr_done;

   screen_clear u_clear (
      .clk   (clk),
      .rst_n (rst_n),
      .start (state == CLEAR),
      .x     (clr_x),
      .y     (clr_y),
      .done  (clr_done)
   );
`endif

   // Next state and next loop variables.
   always_comb begin
      nxt_state = state;
      nxt_off_x = off_x;
      nxt_off_y = off_y;
      nxt_crit  = crit;
      y_new     = off_y + C_ONE;
      x_new     = off_x;
      y_ext     = {{(CRIT_W-COORD_W){y_new[COORD_W-1]}}, y_new};
      x_ext     = '0;
      unique case (state)
         IDLE: begin
            if (start) begin
`ifdef CIRCLE_CLEAR_EN
               nxt_state = CLEAR;
`else
               nxt_state = INIT;
`endif
            end
         end
`ifdef CIRCLE_CLEAR_EN
         CLEAR: begin
            if (clr_done) nxt_state = INIT;
         end
`endif
         INIT: begin
            nxt_off_x = {{(COORD_W-8){1'b0}}, r_r};
            nxt_off_y = '0;
            nxt_crit  = K_ONE - $signed({{(CRIT_W-8){1'b0}}, r_r});
            nxt_state = OCT1;
         end
         OCT1: nxt_state = OCT2;
         OCT2: nxt_state = OCT3;
         OCT3: nxt_state = OCT4;
         OCT4: nxt_state = OCT5;
         OCT5: nxt_state = OCT6;
         OCT6: nxt_state = OCT7;
         OCT7: nxt_state = OCT8;
         OCT8: begin
            // Offsets are kept signed so r=0 can step off_x to -1 and end.
            if (crit[CRIT_W-1] || crit == '0) begin
               nxt_crit = crit + (y_ext <<< 1) + K_ONE;
            end else begin
               x_new    = off_x - C_ONE;
               x_ext    = {{(CRIT_W-COORD_W){x_new[COORD_W-1]}}, x_new};
               nxt_crit = crit + ((y_ext - x_ext) <<< 1) + K_ONE;
            end
            nxt_off_x = x_new;
            nxt_off_y = y_new;
            nxt_state = (y_new <= x_new) ? OCT1 : DONE;
         end
         DONE: begin
            if (!start) nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Candidate point of the state being entered, so the plot outputs can be
   // registered and still be valid for the whole OCTk cycle.
   assign cx_s = {{(COORD_W-8){1'b0}}, cx_r};
   assign cy_s = {{(COORD_W-7){1'b0}}, cy_r};

   always_comb begin
      px     = '0;
      py     = '0;
      is_oct = 1'b1;
      unique case (nxt_state)
         OCT1: begin px = cx_s + nxt_off_x; py = cy_s + nxt_off_y; end
         OCT2: begin px = cx_s + nxt_off_y; py = cy_s + nxt_off_x; end
         OCT3: begin px = cx_s - nxt_off_x; py = cy_s + nxt_off_y; end
         OCT4: begin px = cx_s - nxt_off_y; py = cy_s + nxt_off_x; end
         OCT5: begin px = cx_s - nxt_off_x; py = cy_s - nxt_off_y; end
         OCT6: begin px = cx_s - nxt_off_y; py = cy_s - nxt_off_x; end
         OCT7: begin px = cx_s + nxt_off_x; py = cy_s - nxt_off_y; end
         OCT8: begin px = cx_s + nxt_off_y; py = cy_s - nxt_off_x; end
         default: is_oct = 1'b0;
      endcase
      on_screen = !px[COORD_W-1] && (px <= X_MAX) &&
                  !py[COORD_W-1] && (py <= Y_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cx_r     <= '0;
         cy_r     <= '0;
         r_r      <= '0;
         col_r    <= '0;
         off_x    <= '0;
         off_y    <= '0;
         crit     <= '0;
         done_r   <= 1'b0;
         plot_en  <= 1'b0;
         plot_x   <= '0;
         plot_y   <= '0;
         plot_col <= '0;
      end else begin
         state <= nxt_state;
         off_x <= nxt_off_x;
         off_y <= nxt_off_y;
         crit  <= nxt_crit;
         if (state == IDLE && start) begin
            cx_r  <= centre_x;
            cy_r  <= centre_y;
            r_r   <= radius;
            col_r <= colour;
         end
         done_r <= (nxt_state == DONE);
         if (is_oct) begin
            plot_en  <= on_screen;
            plot_x   <= px[7:0];
            plot_y   <= py[6:0];
            plot_col <= col_r;
         end else begin
            plot_en  <= 1'b0;
            plot_x   <= '0;
            plot_y   <= '0;
            plot_col <= '0;
         end
      end
   end

   assign done = done_r;

`ifdef CIRCLE_CLEAR_EN
   assign vga_x      = (state == CLEAR) ? clr_x : plot_x;
   assign vga_y      = (state == CLEAR) ? clr_y : plot_y;
   assign vga_colour = (state == CLEAR) ? 3'd0  : plot_col;
   assign vga_plot   = (state == CLEAR) ? 1'b1  : plot_en;
`else
   assign vga_x      = plot_x;
   assign vga_y      = plot_y;
   assign vga_colour = plot_col;
   assign vga_plot   = plot_en;
`endif

endmodule

// File: tb/tb_circle_plotter.sv
// tb_circle_plotter: directed self-checking bench for circle_plotter
// (default build, CIRCLE_CLEAR_EN undefined).
module tb_circle_plotter;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] centre_x;
   logic [6:0] centre_y;
   logic [7:0] radius;
   logic [2:0] colour;
   logic       done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   // {plot, x[7:0], y[6:0]} expected per OCT cycle
   logic [15:0] exp_pt [0:15];

   circle_plotter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .centre_x   (centre_x),
      .centre_y   (centre_y),
      .radius     (radius),
      .colour     (colour),
      .done       (done),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] pt(input logic p, input int x, input int y);
      logic [7:0] xb;
      logic [6:0] yb;
      xb = 8'(x);
      yb = 7'(y);
      return {p, xb, yb};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " done"},   done,       0);
      check({tag, " plot"},   vga_plot,   0);
      check({tag, " x"},      vga_x,      0);
      check({tag, " y"},      vga_y,      0);
      check({tag, " colour"}, vga_colour, 0);
   endtask

   // Starts a draw (edge 0 is the next posedge) and checks the first n_chk
   // OCT cycles against exp_pt; if none_plot, every OCT cycle must have
   // vga_plot=0. done must rise exactly on edge 8*n_iter+1.
   task automatic draw(input string tag, input logic [7:0] cx, input logic [6:0] cy,
                       input logic [7:0] r, input logic [2:0] col,
                       input int unsigned n_iter, input int unsigned n_chk,
                       input bit none_plot);
      logic [15:0] e;
      centre_x = cx;
      centre_y = cy;
      radius   = r;
      colour   = col;
      start    = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("%s init plot", tag), vga_plot, 0);
      for (int unsigned k = 1; k <= 8 * n_iter; k++) begin
         @(posedge clk);
         #1;
         if (k <= n_chk) begin
            e = exp_pt[k-1];
            check($sformatf("%s plot[%0d]", tag, k), vga_plot, e[15]);
            if (e[15]) begin
               check($sformatf("%s x[%0d]", tag, k), vga_x, e[14:7]);
               check($sformatf("%s y[%0d]", tag, k), vga_y, e[6:0]);
               check($sformatf("%s colour[%0d]", tag, k), vga_colour, col);
            end
         end else if (none_plot) begin
            check($sformatf("%s noplot[%0d]", tag, k), vga_plot, 0);
         end
      end
      check($sformatf("%s done_early", tag), done, 0);
      @(posedge clk);
      #1;
      check($sformatf("%s done", tag), done, 1);
      check($sformatf("%s done plot", tag), vga_plot, 0);
   endtask

   task automatic release_start(input string tag);
      start = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " release"}, done, 0);
   endtask

   task automatic load_r1_c10;
      exp_pt[0]  = pt(1, 11, 10); exp_pt[1]  = pt(1, 10, 11);
      exp_pt[2]  = pt(1,  9, 10); exp_pt[3]  = pt(1, 10, 11);
      exp_pt[4]  = pt(1,  9, 10); exp_pt[5]  = pt(1, 10,  9);
      exp_pt[6]  = pt(1, 11, 10); exp_pt[7]  = pt(1, 10,  9);
      exp_pt[8]  = pt(1, 11, 11); exp_pt[9]  = pt(1, 11, 11);
      exp_pt[10] = pt(1,  9, 11); exp_pt[11] = pt(1,  9, 11);
      exp_pt[12] = pt(1,  9,  9); exp_pt[13] = pt(1,  9,  9);
      exp_pt[14] = pt(1, 11,  9); exp_pt[15] = pt(1, 11,  9);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      centre_x = '0;
      centre_y = '0;
      radius   = '0;
      colour   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_idle_outputs("idle");

      // 1: r=0 -> eight identical plots at the centre, done on edge 9
      for (int i = 0; i < 8; i++) exp_pt[i] = pt(1, 80, 60);
      draw("t1", 8'd80, 7'd60, 8'd0, 3'd5, 1, 8, 1'b0);

      // 5: hold start after done; done stays high, then drops one edge later
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("t5 hold[%0d]", i), done, 1);
      end
      release_start("t5");
      for (int i = 0; i < 8; i++) exp_pt[i] = pt(1, 30, 40);
      draw("t5new", 8'd30, 7'd40, 8'd0, 3'd2, 1, 8, 1'b0);
      release_start("t5new");

      // 2: r=1 at (10,10), two iterations, done on edge 17
      load_r1_c10();
      draw("t2", 8'd10, 7'd10, 8'd1, 3'd3, 2, 16, 1'b0);
      release_start("t2");

      // 3: r=1 at (0,0), negative candidates clipped, same timing
      exp_pt[0] = pt(1, 1, 0); exp_pt[1] = pt(1, 0, 1);
      exp_pt[2] = pt(0, 0, 0); exp_pt[3] = pt(1, 0, 1);
      exp_pt[4] = pt(0, 0, 0); exp_pt[5] = pt(0, 0, 0);
      exp_pt[6] = pt(1, 1, 0); exp_pt[7] = pt(0, 0, 0);
      draw("t3", 8'd0, 7'd0, 8'd1, 3'd6, 2, 8, 1'b0);
      release_start("t3");

      // 4: centre off-screen right, r=10 -> 8 iterations, never plots
      draw("t4", 8'd200, 7'd60, 8'd10, 3'd1, 8, 0, 1'b1);
      release_start("t4");

      // 6: reset mid-OCT3 of iteration 3 at r=200; (250-200, 10+2) is on-screen
      centre_x = 8'd250;
      centre_y = 7'd10;
      radius   = 8'd200;
      colour   = 3'd7;
      start    = 1'b1;
      @(posedge clk);
      repeat (19) @(posedge clk);
      #1;
      check("t6 pre plot",   vga_plot,   1);
      check("t6 pre x",      vga_x,      50);
      check("t6 pre y",      vga_y,      12);
      check("t6 pre colour", vga_colour, 7);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("t6 rst");
      start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_idle_outputs("t6 post");
      load_r1_c10();
      draw("t6fresh", 8'd10, 7'd10, 8'd1, 3'd4, 2, 16, 1'b0);
      release_start("t6fresh");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
